// File: rtl/clock_ui_pkg.sv
// Shared encodings for the clock UI: display modes, edit modes and edit fields.
// Used by the UI controller and by the time-keeping/display blocks.
package clock_ui_pkg;

    // Display mode (disp_mode)
    localparam logic [2:0] DISP_TIME   = 3'd0;
    localparam logic [2:0] DISP_DATE   = 3'd1;
    localparam logic [2:0] DISP_ALARM  = 3'd2;
    localparam logic [2:0] DISP_TIMER  = 3'd3;
    localparam logic [2:0] DISP_SW     = 3'd4;

    // Edit mode (edit_mode); also the controller state
    localparam logic [1:0] EDIT_IDLE   = 2'd0;
    localparam logic [1:0] EDIT_TIME   = 2'd1;
    localparam logic [1:0] EDIT_ALARM  = 2'd2;
    localparam logic [1:0] EDIT_TIMER  = 2'd3;

    // Edit field (edit_field)
    localparam logic [2:0] FIELD_ALARM_NUM = 3'd0;
    localparam logic [2:0] FIELD_SEC       = 3'd1;
    localparam logic [2:0] FIELD_MIN       = 3'd2;
    localparam logic [2:0] FIELD_HOUR      = 3'd3;
    localparam logic [2:0] FIELD_DAY       = 3'd4;
    localparam logic [2:0] FIELD_MONTH     = 3'd5;
    localparam logic [2:0] FIELD_YEAR      = 3'd6;

    // Decoded press events for one cycle
    typedef struct packed {
        logic mode;
        logic adj;
        logic up;
        logic dn;
    } btn_ev_t;

    // Next field when stepping downward through the fields of an edit mode.
    // Each mode has its own lowest field; stepping below it wraps to the top.
    function automatic logic [2:0] prev_field(input logic [1:0] em, input logic [2:0] f);
        logic [2:0] lo;
        logic [2:0] hi;
        case (em)
            EDIT_TIME:  begin lo = FIELD_SEC;       hi = FIELD_YEAR; end
            EDIT_ALARM: begin lo = FIELD_ALARM_NUM; hi = FIELD_HOUR; end
            default:    begin lo = FIELD_SEC;       hi = FIELD_HOUR; end
        endcase
        return (f == lo) ? hi : f - 3'd1;
    endfunction

endpackage

// File: rtl/clock_ui_ctrl_if.sv
// Button inputs and UI outputs of clock_ui_ctrl, grouped as one bundle.
// slave: the controller; master: whoever drives the buttons and reads the UI state.
interface clock_ui_ctrl_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int SW = $clog2(NUM_ALARMS);

    logic          mode_btn;
    logic          adjust_btn;
    logic          up_btn;
    logic          down_btn;
    logic [2:0]    disp_mode;
    logic [1:0]    edit_mode;
    logic [2:0]    edit_field;
    logic [SW-1:0] alarm_sel;
    logic          inc_pulse;
    logic          dec_pulse;
    logic          commit_pulse;
    logic          cancel_pulse;
    logic          sw_toggle;
    logic          sw_clear;

    modport slave (
        input  mode_btn, adjust_btn, up_btn, down_btn,
        output disp_mode, edit_mode, edit_field, alarm_sel,
        output inc_pulse, dec_pulse, commit_pulse, cancel_pulse, sw_toggle, sw_clear
    );

    modport master (
        output mode_btn, adjust_btn, up_btn, down_btn,
        input  disp_mode, edit_mode, edit_field, alarm_sel,
        input  inc_pulse, dec_pulse, commit_pulse, cancel_pulse, sw_toggle, sw_clear
    );
endinterface

// File: rtl/clock_ui_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus counter debouncer for one
// active-low button. level_o is the debounced level (idle high); press_o is a
// single-cycle pulse registered together with each debounced 1->0 change.
module btn_debounce #(
    parameter int DEB_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronise the raw button; resets to the released (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n_i};
    end

    // Count consecutive cycles the input disagrees with the level; flip on the last one
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/clock_ui_ctrl.sv
// clock_ui_ctrl: four-button UI controller for a digital clock. Debounces the
// buttons, steps display/edit modes and emits single-cycle action pulses.
// Optional feature: define CLOCK_UI_TIMEOUT_EN to abandon an edit session
// after TIMEOUT_CYCLES cycles without a press (cancel_pulse).
module clock_ui_ctrl
    import clock_ui_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int DEB_CYCLES     = 200000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input logic            clk,
    input logic            rst_n,
    clock_ui_ctrl_if.slave ui
);
    localparam int SW = $clog2(NUM_ALARMS);

    logic [3:0] btn_n;
    logic [3:0] press;
    logic [3:0] lvl_unused;
    btn_ev_t    ev;

    assign btn_n = {ui.down_btn, ui.up_btn, ui.adjust_btn, ui.mode_btn};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_n_i (btn_n[i]),
                .level_o (lvl_unused[i]),
                .press_o (press[i])
            );
        end
    endgenerate

    assign ev = '{mode: press[0], adj: press[1], up: press[2], dn: press[3]};

    logic [2:0]    disp_q, disp_d;
    logic [1:0]    edit_q, edit_d;
    logic [2:0]    field_q, field_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          inc_q, inc_d, dec_q, dec_d;
    logic          commit_q, commit_d, cancel_d;
    logic          tog_q, tog_d, clr_q, clr_d;

`ifdef CLOCK_UI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          cancel_q;
    logic          timed_out;

    assign timed_out = (edit_q != EDIT_IDLE) && (idle_q == TW'(TIMEOUT_CYCLES));
`else
    assign cancel_d = 1'b0;
`endif

    // Resolve this cycle's press events (adjust > mode > up/down) into next UI state
    always_comb begin
        disp_d   = disp_q;
        edit_d   = edit_q;
        field_d  = field_q;
        sel_d    = sel_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        tog_d    = 1'b0;
        clr_d    = 1'b0;
`ifdef CLOCK_UI_TIMEOUT_EN
        cancel_d = 1'b0;
`endif
        if (ev.adj) begin
            if (edit_q == EDIT_IDLE) begin
                field_d = FIELD_HOUR;
                case (disp_q)
                    DISP_TIME, DISP_DATE: edit_d = EDIT_TIME;
                    DISP_ALARM:           edit_d = EDIT_ALARM;
                    DISP_TIMER:           edit_d = EDIT_TIMER;
                    default:              tog_d  = 1'b1;
                endcase
            end else begin
                commit_d = 1'b1;
                edit_d   = EDIT_IDLE;
                field_d  = FIELD_HOUR;
            end
        end else if (ev.mode) begin
            if (edit_q == EDIT_IDLE)
                disp_d = (disp_q == DISP_SW) ? DISP_TIME : disp_q + 3'd1;
            else
                field_d = prev_field(edit_q, field_q);
        end else if (ev.up ^ ev.dn) begin
            if (edit_q == EDIT_IDLE) begin
                clr_d = (disp_q == DISP_SW) && ev.dn;
            end else if (field_q == FIELD_ALARM_NUM) begin
                // Alarm slot count need not be a power of two, so wrap explicitly
                if (ev.up) sel_d = (sel_q == SW'(NUM_ALARMS - 1)) ? '0 : sel_q + 1'b1;
                else       sel_d = (sel_q == '0) ? SW'(NUM_ALARMS - 1) : sel_q - 1'b1;
            end else begin
                inc_d = ev.up;
                dec_d = ev.dn;
            end
        end
`ifdef CLOCK_UI_TIMEOUT_EN
        // A press in the same cycle counts as activity and wins over the timeout
        else if (timed_out) begin
            cancel_d = 1'b1;
            edit_d   = EDIT_IDLE;
            field_d  = FIELD_HOUR;
        end
`endif
    end

`ifdef CLOCK_UI_TIMEOUT_EN
    // Idle counter: zero in IDLE, restarted by any press, free-running while editing
    always_comb begin
        idle_d = idle_q + 1'b1;
        if (edit_d == EDIT_IDLE || (|press)) idle_d = '0;
    end

    // Idle counter and cancel pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q   <= '0;
            cancel_q <= 1'b0;
        end else begin
            idle_q   <= idle_d;
            cancel_q <= cancel_d;
        end
    end

    assign ui.cancel_pulse = cancel_q;
`else
    assign ui.cancel_pulse = cancel_d;
`endif

    // UI state and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= DISP_TIME;
            edit_q   <= EDIT_IDLE;
            field_q  <= FIELD_HOUR;
            sel_q    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
            tog_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            disp_q   <= disp_d;
            edit_q   <= edit_d;
            field_q  <= field_d;
            sel_q    <= sel_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            commit_q <= commit_d;
            tog_q    <= tog_d;
            clr_q    <= clr_d;
        end
    end

    assign ui.disp_mode    = disp_q;
    assign ui.edit_mode    = edit_q;
    assign ui.edit_field   = field_q;
    assign ui.alarm_sel    = sel_q;
    assign ui.inc_pulse    = inc_q;
    assign ui.dec_pulse    = dec_q;
    assign ui.commit_pulse = commit_q;
    assign ui.sw_toggle    = tog_q;
    assign ui.sw_clear     = clr_q;
endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Directed bench for clock_ui_ctrl with DEB_CYCLES=4, TIMEOUT_CYCLES=50,
// NUM_ALARMS=4. Pulses are tallied on the falling edge and compared as
// running totals against hand-computed values.
module tb_clock_ui_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    clock_ui_ctrl_if #(.NUM_ALARMS(4)) ui ();

    clock_ui_ctrl #(.NUM_ALARMS(4), .DEB_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ui    (ui)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_inc = 0, n_dec = 0, n_com = 0, n_can = 0, n_tog = 0, n_clr = 0, n_multi = 0;

    always @(negedge clk) begin
        if (ui.inc_pulse)    n_inc++;
        if (ui.dec_pulse)    n_dec++;
        if (ui.commit_pulse) n_com++;
        if (ui.cancel_pulse) n_can++;
        if (ui.sw_toggle)    n_tog++;
        if (ui.sw_clear)     n_clr++;
        if ($countones({ui.inc_pulse, ui.dec_pulse, ui.commit_pulse,
                        ui.cancel_pulse, ui.sw_toggle, ui.sw_clear}) > 1) n_multi++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // m bits: 0 mode, 1 adjust, 2 up, 3 down; hold for 'hold' cycles then release
    task automatic drive(input logic [3:0] m, input int hold);
        @(negedge clk);
        ui.mode_btn   = ~m[0];
        ui.adjust_btn = ~m[1];
        ui.up_btn     = ~m[2];
        ui.down_btn   = ~m[3];
        repeat (hold) @(negedge clk);
        ui.mode_btn   = 1'b1;
        ui.adjust_btn = 1'b1;
        ui.up_btn     = 1'b1;
        ui.down_btn   = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        drive(m, 8);
    endtask

    localparam logic [3:0] B_MODE = 4'b0001;
    localparam logic [3:0] B_ADJ  = 4'b0010;
    localparam logic [3:0] B_UP   = 4'b0100;
    localparam logic [3:0] B_DN   = 4'b1000;

    task automatic chk_state(input string tag, input int d, input int e, input int f, input int s);
        chk({tag, ".disp"},  int'(ui.disp_mode),  d);
        chk({tag, ".edit"},  int'(ui.edit_mode),  e);
        chk({tag, ".field"}, int'(ui.edit_field), f);
        chk({tag, ".sel"},   int'(ui.alarm_sel),  s);
    endtask

    initial begin
        ui.mode_btn = 1'b1; ui.adjust_btn = 1'b1; ui.up_btn = 1'b1; ui.down_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk_state("reset", 0, 0, 3, 0);
        chk("reset.pulses", int'({ui.inc_pulse, ui.dec_pulse, ui.commit_pulse,
                                  ui.cancel_pulse, ui.sw_toggle, ui.sw_clear}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Short glitch is filtered; long hold counts once
        drive(B_MODE, 3);
        chk("glitch.disp", int'(ui.disp_mode), 0);
        drive(B_MODE, 20);
        chk("hold.disp", int'(ui.disp_mode), 1);

        press(B_MODE); chk("mode2", int'(ui.disp_mode), 2);
        press(B_MODE); chk("mode3", int'(ui.disp_mode), 3);
        press(B_MODE); chk("mode4", int'(ui.disp_mode), 4);

        // Stopwatch controls
        press(B_ADJ);
        chk("sw.tog", n_tog, 1);
        chk("sw.edit", int'(ui.edit_mode), 0);
        press(B_DN); chk("sw.clr", n_clr, 1);
        press(B_UP); chk("sw.up_ignored", n_inc, 0);
        press(B_MODE); chk("mode_wrap", int'(ui.disp_mode), 0);

        // TIME edit session
        press(B_ADJ);  chk_state("tedit", 0, 1, 3, 0);
        press(B_MODE); chk("tedit.f2", int'(ui.edit_field), 2);
        press(B_MODE); chk("tedit.f1", int'(ui.edit_field), 1);
        press(B_MODE); chk("tedit.f6", int'(ui.edit_field), 6);
        press(B_UP);   chk("tedit.inc", n_inc, 1);
        press(B_DN);   chk("tedit.dec", n_dec, 1);
        press(B_UP | B_DN);
        chk("tedit.updn_inc", n_inc, 1);
        chk("tedit.updn_dec", n_dec, 1);
        press(B_ADJ);
        chk("tedit.commit", n_com, 1);
        chk_state("tedit.done", 0, 0, 3, 0);
        press(B_UP); chk("idle.up_ignored", n_inc, 1);

        // ALARM edit session with slot selection
        press(B_MODE); press(B_MODE);
        press(B_ADJ);  chk_state("aedit", 2, 2, 3, 0);
        press(B_MODE); press(B_MODE); press(B_MODE);
        chk("aedit.f0", int'(ui.edit_field), 0);
        press(B_DN);
        chk("aedit.sel3", int'(ui.alarm_sel), 3);
        chk("aedit.nodec", n_dec, 1);
        press(B_UP); press(B_UP);
        chk("aedit.sel1", int'(ui.alarm_sel), 1);
        chk("aedit.noinc", n_inc, 1);
        press(B_MODE); chk("aedit.wrap", int'(ui.edit_field), 3);
        press(B_UP);   chk("aedit.inc", n_inc, 2);
        press(B_ADJ);
        chk("aedit.commit", n_com, 2);
        chk_state("aedit.done", 2, 0, 3, 1);

        // Adjust beats mode in the same cycle
        press(B_MODE);
        press(B_ADJ | B_MODE);
        chk_state("prio", 3, 3, 3, 1);
        press(B_MODE); press(B_MODE);
        chk("timer.f1", int'(ui.edit_field), 1);
        press(B_MODE); chk("timer.wrap", int'(ui.edit_field), 3);
        press(B_ADJ);  chk("timer.commit", n_com, 3);

        // Idle timeout in TIME edit
        press(B_MODE); press(B_MODE);
        press(B_ADJ);
        chk("to.enter", int'(ui.edit_mode), 1);
        repeat (60) @(negedge clk);
`ifdef CLOCK_UI_TIMEOUT_EN
        chk("to.cancel", n_can, 1);
        chk_state("to.idle", 0, 0, 3, 1);
        press(B_ADJ);
`else
        chk("to.nocancel", n_can, 0);
        chk("to.stays", int'(ui.edit_mode), 1);
`endif
        press(B_MODE);
        chk("pre_rst.field", int'(ui.edit_field), 2);

        // Reset mid-edit and mid-debounce
        @(negedge clk);
        ui.mode_btn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_state("midrst", 0, 0, 3, 0);
        ui.mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst.disp", int'(ui.disp_mode), 0);
        chk("midrst.commit", n_com, 3);
`ifdef CLOCK_UI_TIMEOUT_EN
        chk("midrst.cancel", n_can, 1);
`else
        chk("midrst.cancel", n_can, 0);
`endif
        chk("onehot", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
